reg_file_dump: RTL

Debug read-out engine for the core's 32×32 register file. On a start pulse it walks every register through a dedicated read port and streams the contents as a little-endian byte stream over a valid/ready interface, for a UART or debug-bridge transmitter. It sits beside the register file on a spare asynchronous read port and never writes the register file.

---
 rtl/reg_file_dump.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/reg_file_dump.sv
// reg_file_dump: walks a register file through a spare asynchronous read port
// and streams every register as little-endian bytes over valid/ready.
// Optional feature: define REG_DUMP_CSUM_EN to append one byte holding the
// 8-bit modular sum of all data bytes after the last register.
module reg_file_dump #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(NUM_REGS - 1);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(BYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_SEND = 3'd2,
    S_DONE = 3'd3
`ifdef REG_DUMP_CSUM_EN
    , S_CSUM = 3'd4
`endif
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [DATA_W-1:0] word_q, word_d;
`ifdef REG_DUMP_CSUM_EN
  logic [7:0]        sum_q, sum_d;
`endif
  logic              hs;

  assign hs         = tx_valid & tx_ready;
  // The read address is the register index itself, so it never glitches.
  assign rf_rd_addr = idx_q;

  // State and datapath registers; reset abandons any dump in progress.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      byte_cnt_q <= '0;
      word_q     <= '0;
`ifdef REG_DUMP_CSUM_EN
      sum_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
`ifdef REG_DUMP_CSUM_EN
      sum_q      <= sum_d;
`endif
    end
  end

  // Next-state logic: sample a register in LOAD, shift it out byte by byte in SEND.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
`ifdef REG_DUMP_CSUM_EN
    sum_d      = sum_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_LOAD;
          idx_d      = '0;
          byte_cnt_d = '0;
`ifdef REG_DUMP_CSUM_EN
          sum_d      = '0;
`endif
        end
      end
      S_LOAD: begin
        // Live sample: whatever the register holds in this cycle is what goes out.
        word_d  = rf_rd_data;
        state_d = S_SEND;
      end
      S_SEND: begin
        if (hs) begin
          word_d     = word_q >> 8;
          byte_cnt_d = byte_cnt_q + CNT_W'(1);
`ifdef REG_DUMP_CSUM_EN
          sum_d      = sum_q + word_q[7:0];
`endif
          if (byte_cnt_q == LAST_BYTE) begin
            byte_cnt_d = '0;
            if (idx_q == LAST_IDX) begin
`ifdef REG_DUMP_CSUM_EN
              state_d = S_CSUM;
`else
              state_d = S_DONE;
`endif
            end else begin
              idx_d   = idx_q + ADDR_W'(1);
              state_d = S_LOAD;
            end
          end
        end
      end
`ifdef REG_DUMP_CSUM_EN
      S_CSUM: begin
        if (hs) state_d = S_DONE;
      end
`endif
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decode registered state only; tx_ready and rf_rd_data never reach them.
  always_comb begin
    busy     = (state_q != S_IDLE);
    done     = (state_q == S_DONE);
    tx_valid = 1'b0;
    tx_data  = '0;
    case (state_q)
      S_SEND: begin
        tx_valid = 1'b1;
        tx_data  = word_q[7:0];
      end
`ifdef REG_DUMP_CSUM_EN
      S_CSUM: begin
        tx_valid = 1'b1;
        tx_data  = sum_q;
      end
`endif
      default: begin
        tx_valid = 1'b0;
        tx_data  = '0;
      end
    endcase
  end

endmodule
